// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the cache-line memory responder.
package mem_if_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned OFFSET_BITS    = $clog2(DEF_LINE_WORDS);
    localparam int unsigned BYTE_OFF_BITS  = $clog2(DEF_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        WACK
    } state_e;

    // Byte address -> word index of the first word of its line.
    function automatic logic [63:0] line_index(input logic [63:0] addr,
                                               input int unsigned byte_bits,
                                               input int unsigned off_bits);
        logic [63:0] word;
        word = addr >> byte_bits;
        return (word >> off_bits) << off_bits;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Word storage: synchronous write port, asynchronous read port.
module mem_line_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; contents must survive rst_ni and a reset
    // would also prevent mapping onto RAM macros.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_line_responder.sv
// Line-granular refill / write-back responder with fixed access latency,
// streaming one word per valid/ready beat.
module mem_line_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  wdata_valid_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wdata_ready_o,
    output logic                  rdata_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_last_o,
    input  logic                  rdata_ready_i,
    output logic                  wack_o,
    output logic                  busy_o
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_e              state_q;
    logic [3:0]          lat_q;
    logic [OFF_W-1:0]    beat_q;
    logic [MEM_AW-1:0]   base_q;
    logic                we_q;
    logic                req_ready_q, wdata_ready_q, rdata_valid_q;
    logic                rdata_last_q, wack_q, busy_q;

    logic [MEM_AW-1:0]     base_d;
    logic [MEM_AW-1:0]     word_addr;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic                  arr_we;

    // Truncation to MEM_AW bits is what makes out-of-range addresses wrap.
    assign base_d    = MEM_AW'(line_index(64'(req_addr_i), BYTE_W, OFF_W));
    assign word_addr = base_q + MEM_AW'(beat_q);
    assign arr_we    = wdata_ready_q && wdata_valid_i;

    mem_line_array #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MEM_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .waddr_i (word_addr),
        .wdata_i (wdata_i),
        .raddr_i (word_addr),
        .rdata_o (arr_rdata)
    );

    // NOTE: all FSM state and registered outputs use non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            lat_q         <= '0;
            beat_q        <= '0;
            base_q        <= '0;
            we_q          <= 1'b0;
            req_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            wack_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        base_q      <= base_d;
                        we_q        <= req_we_i;
                        lat_q       <= 4'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        if (we_q) begin
                            wdata_ready_q <= 1'b1;
                            state_q       <= WBURST;
                        end else begin
                            rdata_valid_q <= 1'b1;
                            rdata_last_q  <= (LAST_BEAT == '0);
                            state_q       <= RBURST;
                        end
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                RBURST: begin
                    if (rdata_ready_i) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q        <= '0;
                            rdata_valid_q <= 1'b0;
                            rdata_last_q  <= 1'b0;
                            req_ready_q   <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= IDLE;
                        end else begin
                            beat_q       <= beat_q + OFF_W'(1);
                            rdata_last_q <= (beat_q + OFF_W'(1) == LAST_BEAT);
                        end
                    end
                end
                WBURST: begin
                    if (wdata_valid_i) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q        <= '0;
                            wdata_ready_q <= 1'b0;
                            wack_q        <= 1'b1;
                            state_q       <= WACK;
                        end else begin
                            beat_q <= beat_q + OFF_W'(1);
                        end
                    end
                end
                WACK: begin
                    wack_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign wdata_ready_o = wdata_ready_q;
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_last_o  = rdata_last_q;
    assign wack_o        = wack_q;
    assign busy_o        = busy_q;
    assign rdata_o       = (state_q == RBURST) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder against a word-array reference model.
module tb_mem_line_responder;

    localparam int unsigned LATENCY   = 3;
    localparam int unsigned MEM_WORDS = 1024;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] wdata_i;
    logic        rdata_valid_o, rdata_last_o, rdata_ready_i;
    logic [31:0] rdata_o;
    logic        wack_o, busy_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] written_q [$];

    mem_line_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LINE_WORDS (4),
        .MEM_WORDS  (MEM_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_i       (wdata_i),
        .wdata_ready_o (wdata_ready_o),
        .rdata_valid_o (rdata_valid_o),
        .rdata_o       (rdata_o),
        .rdata_last_o  (rdata_last_o),
        .rdata_ready_i (rdata_ready_i),
        .wack_o        (wack_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First word of the line holding a byte address: 4-byte words, 4-word lines.
    function automatic int unsigned line_of(input logic [31:0] addr);
        int unsigned word;
        word = addr / 4;
        return ((word / 4) * 4) % MEM_WORDS;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_rvalid"}, rdata_valid_o, 0);
        check({tag, "_rdata"}, rdata_o, 0);
        check({tag, "_rlast"}, rdata_last_o, 0);
        check({tag, "_wready"}, wdata_ready_o, 0);
        check({tag, "_wack"}, wack_o, 0);
    endtask

    // Write-back of four beats; abort_at < 4 pulls reset after that many beats.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] d0, d1, d2, d3,
                            input bit stall, input bit early_wv, input int abort_at);
        logic [31:0] d [4];
        int unsigned base;
        int cyc, i;
        bit r, v;
        d = '{d0, d1, d2, d3};
        base = line_of(addr);
        @(negedge clk_i);
        check("wr_req_ready", req_ready_o, 1);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = addr;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("wr_busy", busy_o, 1);
        check("wr_req_ready_low", req_ready_o, 0);
        if (early_wv) begin
            wdata_valid_i = 1'b1;
            wdata_i = 32'hDEAD_BEEF;
        end
        cyc = 0;
        while (!wdata_ready_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        check("wr_latency", cyc, LATENCY);
        i = 0; cyc = 0;
        while (i < abort_at && cyc < 60) begin
            r = wdata_ready_o;
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            check("wr_ready_in_burst", r, 1);
            wdata_valid_i = v;
            wdata_i = v ? d[i] : $urandom;
            @(negedge clk_i);
            cyc++;
            if (r && v) begin
                model_mem[base + i] = d[i];
                i++;
            end
        end
        wdata_valid_i = 1'b0;
        check("wr_beats", i, abort_at);
        if (abort_at < 4) begin
            #2 rst_ni = 1'b0;
            #1 check_idle_outputs("rst_async");
            @(negedge clk_i);
            rst_ni = 1'b1;
            return;
        end
        check("wr_wack", wack_o, 1);
        check("wr_ready_off", wdata_ready_o, 0);
        @(negedge clk_i);
        check("wr_wack_pulse", wack_o, 0);
        check("wr_done_ready", req_ready_o, 1);
        check("wr_done_busy", busy_o, 0);
        written_q.push_back(addr);
    endtask

    // Refill; mode 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random.
    task automatic do_read(input logic [31:0] addr, input int mode, input bit hold_req);
        int unsigned base;
        int cyc, beat, p;
        bit rdy;
        base = line_of(addr);
        @(negedge clk_i);
        check("rd_req_ready", req_ready_o, 1);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = addr;
        @(negedge clk_i);
        if (!hold_req) req_valid_i = 1'b0;
        req_addr_i = 32'h0000_0100;
        cyc = 0;
        while (!rdata_valid_o && cyc < 50) begin
            if (hold_req) check("rd_no_accept_wait", req_ready_o, 0);
            @(negedge clk_i);
            cyc++;
        end
        check("rd_latency", cyc, LATENCY);
        beat = 0; cyc = 0; p = 0;
        while (beat < 4 && cyc < 60) begin
            check("rd_valid", rdata_valid_o, 1);
            check("rd_data", rdata_o, model_mem[base + beat]);
            check("rd_last", rdata_last_o, (beat == 3));
            if (hold_req) check("rd_no_accept_burst", req_ready_o, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (p % 4 == 0) || (p % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            p++;
            rdata_ready_i = rdy;
            @(negedge clk_i);
            cyc++;
            if (rdy) beat++;
        end
        rdata_ready_i = 1'b0;
        req_valid_i = 1'b0;
        check("rd_handshakes", beat, 4);
        check_idle_outputs("rd_done");
    endtask

    initial begin
        int unsigned n_ops;
        logic [31:0] a;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        wdata_valid_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b0;
        #23;
        check_idle_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("post_reset");

        // Preload words 16..19 and refill them with the cache always ready.
        do_write(32'h40, 32'hA, 32'hB, 32'hC, 32'hD, 1'b0, 1'b0, 4);
        do_read(32'h40, 0, 1'b0);

        // Low offset bits of the refill address are ignored.
        do_write(32'h80, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b0, 4);
        do_read(32'h8C, 0, 1'b0);

        // Stalled refill, then request held high during a burst.
        do_read(32'h80, 1, 1'b0);
        do_read(32'h44, 0, 1'b1);

        // Write beats presented during WAIT must not be taken early.
        do_write(32'h200, 32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003,
                 1'b0, 1'b1, 4);
        do_read(32'h200, 0, 1'b0);

        // Address 0x1000 wraps onto word 0.
        do_write(32'h1000, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
                 1'b0, 1'b0, 4);
        do_read(32'h0, 0, 1'b0);
        do_read(32'h1008, 2, 1'b0);

        // Reset after two beats of a write-back: old tail survives.
        do_write(32'h300, 32'h0100, 32'h0101, 32'h0102, 32'h0103, 1'b0, 1'b0, 4);
        do_write(32'h300, 32'h0200, 32'h0201, 32'h0202, 32'h0203, 1'b0, 1'b0, 2);
        do_read(32'h300, 0, 1'b0);

        // Randomized traffic over the full address space with random stalls.
        n_ops = 14;
        for (int t = 0; t < int'(n_ops); t++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom;
                do_write(a, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'($urandom_range(0, 1)), 4);
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                a = ((a & 32'hFFFF_FFF0) | ($urandom & 32'hF)) + ($urandom_range(0, 15) << 12);
                do_read(a, 2, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
